// File: rtl/mem_stage_pkg.sv
// Shared types and address decode for the MEM pipeline stage.
// Optional perf counters: define MEM_STAGE_PERF_CNT_EN.
package mem_stage_pkg;

    localparam int MS_DATA_W = 24;
    localparam int MS_DEST_W = 4;

    typedef enum logic [1:0] {
        REG_IMG,
        REG_SIN,
        REG_RAM,
        REG_UNMAP
    } region_e;

    typedef struct packed {
        logic                 wb_en;
        logic                 rd_en;
        logic [MS_DEST_W-1:0] dest;
        logic [MS_DATA_W-1:0] alu_result;
        logic [MS_DATA_W-1:0] mem_data;
        logic                 err;
    } mem_entry_t;

    function automatic region_e region_decode(
        input logic [31:0] addr,
        input int unsigned img_size,
        input int unsigned sin_size,
        input int unsigned ram_size
    );
        region_e r;
        if (addr < img_size)
            r = REG_IMG;
        else if (addr < img_size + sin_size)
            r = REG_SIN;
        else if (addr < img_size + sin_size + ram_size)
            r = REG_RAM;
        else
            r = REG_UNMAP;
        return r;
    endfunction

    function automatic logic [31:0] region_base(
        input region_e     r,
        input int unsigned img_size,
        input int unsigned sin_size
    );
        logic [31:0] b;
        unique case (r)
            REG_SIN: b = img_size;
            REG_RAM: b = img_size + sin_size;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_stage_skid_fifo.sv
// Output skid FIFO of mem_entry_t for the MEM stage.
// Caller guarantees no push when full and no pop when empty.
module mem_stage_skid_fifo
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  mem_entry_t    push_data,
    input  logic          pop,
    output mem_entry_t    head,
    output logic [CW-1:0] count
);

    mem_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1))
            n = '0;
        else
            n = p + PW'(1);
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= inc(wr_ptr);
            if (pop)
                rd_ptr <= inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage: region decode, sync-memory drive, skid FIFO, display port B.
// Optional perf counters: define MEM_STAGE_PERF_CNT_EN.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = MS_DATA_W,
    parameter int DEST_W     = MS_DEST_W,
    parameter int LOC_W      = 17,
    parameter int IMG_SIZE   = 90000,
    parameter int SIN_SIZE   = 300,
    parameter int RAM_SIZE   = 65536,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_rd_en,
    input  logic              in_wr_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_rd_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              out_err,
    output logic [LOC_W-1:0]  img_addr_a,
    output logic [LOC_W-1:0]  sin_addr,
    output logic [LOC_W-1:0]  ram_addr_a,
    output logic              img_rden_a,
    output logic              sin_rden,
    output logic              ram_rden_a,
    output logic              ram_wren_a,
    output logic [DATA_W-1:0] ram_wdata_a,
    input  logic [DATA_W-1:0] img_q_a,
    input  logic [DATA_W-1:0] sin_q,
    input  logic [DATA_W-1:0] ram_q_a,
    input  logic [LOC_W:0]    b_addr,
    output logic [DATA_W-1:0] b_data,
    output logic [LOC_W-1:0]  img_addr_b,
    output logic [LOC_W-1:0]  ram_addr_b,
    input  logic [DATA_W-1:0] img_q_b,
    input  logic [DATA_W-1:0] ram_q_b
`ifdef MEM_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    logic          acc;
    region_e       a_reg;
    logic [31:0]   a_abs;
    logic [LOC_W-1:0] a_loc;
    logic          a_err;

    logic          s1_valid;
    region_e       s1_region;
    mem_entry_t    s1_ent;
    mem_entry_t    push_ent;
    logic [DATA_W-1:0] q_mux;

    mem_entry_t    head;
    logic [CW-1:0] fcount;
    logic [CW:0]   occ;
    logic          pop;

    region_e       b_reg;
    region_e       b_reg_q;
    logic [31:0]   b_abs;
    logic [LOC_W-1:0] b_loc;

    assign a_abs = 32'(in_alu_result);
    assign a_reg = region_decode(a_abs, IMG_SIZE, SIN_SIZE, RAM_SIZE);
    assign a_loc = LOC_W'(a_abs - region_base(a_reg, IMG_SIZE, SIN_SIZE));
    assign a_err = (in_wr_en && a_reg != REG_RAM)
                || (in_rd_en && a_reg == REG_UNMAP);

    // Count is registered so out_ready never reaches in_ready combinationally.
    assign occ      = {1'b0, fcount} + (CW+1)'(s1_valid);
    assign in_ready = rst && (occ < (CW+1)'(SKID_DEPTH));
    assign acc      = in_valid && in_ready;

    always_comb begin
        img_addr_a  = '0;
        sin_addr    = '0;
        ram_addr_a  = '0;
        img_rden_a  = 1'b0;
        sin_rden    = 1'b0;
        ram_rden_a  = 1'b0;
        ram_wren_a  = 1'b0;
        ram_wdata_a = '0;
        unique case (a_reg)
            REG_IMG: begin
                img_addr_a = a_loc;
                img_rden_a = acc && in_rd_en;
            end
            REG_SIN: begin
                sin_addr = a_loc;
                sin_rden = acc && in_rd_en;
            end
            REG_RAM: begin
                ram_addr_a  = a_loc;
                ram_rden_a  = acc && in_rd_en;
                ram_wren_a  = acc && in_wr_en;
                ram_wdata_a = in_wdata;
            end
            REG_UNMAP: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_region <= REG_UNMAP;
            s1_ent    <= '0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_region         <= a_reg;
                s1_ent.wb_en      <= in_wb_en;
                s1_ent.rd_en      <= in_rd_en;
                s1_ent.dest       <= MS_DEST_W'(in_dest);
                s1_ent.alu_result <= MS_DATA_W'(in_alu_result);
                s1_ent.mem_data   <= '0;
                s1_ent.err        <= a_err;
            end
        end
    end

    always_comb begin
        q_mux = '0;
        unique case (s1_region)
            REG_IMG:   q_mux = img_q_a;
            REG_SIN:   q_mux = sin_q;
            REG_RAM:   q_mux = ram_q_a;
            REG_UNMAP: q_mux = '0;
        endcase
    end

    always_comb begin
        push_ent          = s1_ent;
        push_ent.mem_data = s1_ent.rd_en ? MS_DATA_W'(q_mux) : '0;
    end

    assign pop = out_valid && out_ready;

    mem_stage_skid_fifo #(
        .DEPTH(SKID_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s1_valid),
        .push_data(push_ent),
        .pop      (pop),
        .head     (head),
        .count    (fcount)
    );

    assign out_valid      = (fcount != '0);
    assign out_wb_en      = out_valid && head.wb_en;
    assign out_rd_en      = out_valid && head.rd_en;
    assign out_err        = out_valid && head.err;
    assign out_dest       = out_valid ? DEST_W'(head.dest) : '0;
    assign out_alu_result = out_valid ? DATA_W'(head.alu_result) : '0;
    assign out_mem_data   = out_valid ? DATA_W'(head.mem_data) : '0;

    assign b_abs = 32'(b_addr);
    assign b_reg = region_decode(b_abs, IMG_SIZE, SIN_SIZE, RAM_SIZE);
    assign b_loc = LOC_W'(b_abs - region_base(b_reg, IMG_SIZE, SIN_SIZE));

    assign img_addr_b = (b_reg == REG_IMG) ? b_loc : '0;
    assign ram_addr_b = (b_reg == REG_RAM) ? b_loc : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            b_reg_q <= REG_UNMAP;
        else
            b_reg_q <= b_reg;
    end

    always_comb begin
        b_data = '0;
        unique case (b_reg_q)
            REG_IMG:   b_data = img_q_b;
            REG_RAM:   b_data = ram_q_b;
            REG_SIN,
            REG_UNMAP: b_data = '0;
        endcase
    end

`ifdef MEM_STAGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_stall  <= '0;
        end else begin
            if (acc && in_rd_en && perf_loads != '1)
                perf_loads <= perf_loads + 32'd1;
            if (acc && in_wr_en && perf_stores != '1)
                perf_stores <= perf_stores + 32'd1;
            if (in_valid && !in_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with behavioural sync memories.
// Optional perf ports follow MEM_STAGE_PERF_CNT_EN.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        in_wb_en, in_rd_en, in_wr_en;
    logic [3:0]  in_dest;
    logic [23:0] in_alu_result, in_wdata;
    logic        out_valid, out_ready;
    logic        out_wb_en, out_rd_en, out_err;
    logic [3:0]  out_dest;
    logic [23:0] out_alu_result, out_mem_data;
    logic [16:0] img_addr_a, sin_addr, ram_addr_a;
    logic        img_rden_a, sin_rden, ram_rden_a, ram_wren_a;
    logic [23:0] ram_wdata_a;
    logic [23:0] img_q_a, sin_q, ram_q_a;
    logic [17:0] b_addr;
    logic [23:0] b_data;
    logic [16:0] img_addr_b, ram_addr_b;
    logic [23:0] img_q_b, ram_q_b;
`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [23:0] q_alu [$];
    logic [23:0] q_data [$];

    mem_stage_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wb_en      (in_wb_en),
        .in_rd_en      (in_rd_en),
        .in_wr_en      (in_wr_en),
        .in_dest       (in_dest),
        .in_alu_result (in_alu_result),
        .in_wdata      (in_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wb_en     (out_wb_en),
        .out_rd_en     (out_rd_en),
        .out_dest      (out_dest),
        .out_alu_result(out_alu_result),
        .out_mem_data  (out_mem_data),
        .out_err       (out_err),
        .img_addr_a    (img_addr_a),
        .sin_addr      (sin_addr),
        .ram_addr_a    (ram_addr_a),
        .img_rden_a    (img_rden_a),
        .sin_rden      (sin_rden),
        .ram_rden_a    (ram_rden_a),
        .ram_wren_a    (ram_wren_a),
        .ram_wdata_a   (ram_wdata_a),
        .img_q_a       (img_q_a),
        .sin_q         (sin_q),
        .ram_q_a       (ram_q_a),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .img_addr_b    (img_addr_b),
        .ram_addr_b    (ram_addr_b),
        .img_q_b       (img_q_b),
        .ram_q_b       (ram_q_b)
`ifdef MEM_STAGE_PERF_CNT_EN
        ,
        .perf_loads    (perf_loads),
        .perf_stores   (perf_stores),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memories return a tag plus the local address one cycle after the read.
    always @(posedge clk) begin
        if (img_rden_a) img_q_a <= {7'h21, img_addr_a};
        if (sin_rden)   sin_q   <= {7'h32, sin_addr};
        if (ram_rden_a) ram_q_a <= {7'h43, ram_addr_a};
        img_q_b <= {7'h54, img_addr_b};
        ram_q_b <= {7'h65, ram_addr_b};
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_alu.push_back(out_alu_result);
            q_data.push_back(out_mem_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [3:0] dest, input logic [23:0] alu,
                         input logic [23:0] wdata);
        in_valid      = 1'b1;
        in_wb_en      = wb;
        in_rd_en      = rd;
        in_wr_en      = wr;
        in_dest       = dest;
        in_alu_result = alu;
        in_wdata      = wdata;
    endtask

    task automatic wait_accept(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] dest,
                              input logic [23:0] alu, input logic [23:0] data,
                              input logic err);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_dest"}, 32'(out_dest), 32'(dest));
        chk({tag, "_alu"}, 32'(out_alu_result), 32'(alu));
        chk({tag, "_data"}, 32'(out_mem_data), 32'(data));
        chk({tag, "_err"}, 32'(out_err), 32'(err));
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_wb_en = 1'b0;
        in_rd_en = 1'b0;
        in_wr_en = 1'b0;
        in_dest = '0;
        in_alu_result = '0;
        in_wdata = '0;
        out_ready = 1'b0;
        b_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mem_data", 32'(out_mem_data), 0);
        chk("rst_b_data", 32'(b_data), 0);
        chk("rst_img_rden", 32'(img_rden_a), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);

        // 1: IMG load, two-cycle latency
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(1, 1, 0, 4'd3, 24'd5, 24'd0);
        @(negedge clk);
        chk("t1_in_ready", 32'(in_ready), 1);
        chk("t1_img_rden", 32'(img_rden_a), 1);
        chk("t1_img_addr", 32'(img_addr_a), 5);
        chk("t1_sin_rden", 32'(sin_rden), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat1_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_lat2_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_mem_data), 32'h420005);
        chk("t1_err", 32'(out_err), 0);
        chk("t1_dest", 32'(out_dest), 3);
        chk("t1_wb", 32'(out_wb_en), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_popped", 32'(out_valid), 0);

        // 2: SIN load then RAM store back to back
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'd4, 24'd90010, 24'd0);
        @(negedge clk);
        chk("t2_sin_rden", 32'(sin_rden), 1);
        chk("t2_sin_addr", 32'(sin_addr), 10);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 4'd0, 24'd90300, 24'hABCDEF);
        @(negedge clk);
        chk("t2_in_ready", 32'(in_ready), 1);
        chk("t2_ram_wren", 32'(ram_wren_a), 1);
        chk("t2_ram_rden", 32'(ram_rden_a), 0);
        chk("t2_ram_addr", 32'(ram_addr_a), 0);
        chk("t2_ram_wdata", 32'(ram_wdata_a), 32'hABCDEF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_out("t2_ld", 4'd4, 24'd90010, 24'h64000A, 1'b0);
        expect_out("t2_st", 4'd0, 24'd90300, 24'd0, 1'b0);

        // 3: faulting store and unmapped load
        @(posedge clk);
        #1;
        drive(0, 0, 1, 4'd0, 24'd100, 24'h123456);
        @(negedge clk);
        chk("t3_st_img_rden", 32'(img_rden_a), 0);
        chk("t3_st_ram_wren", 32'(ram_wren_a), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_out("t3_st", 4'd0, 24'd100, 24'd0, 1'b1);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'd7, 24'd155836, 24'd0);
        @(negedge clk);
        chk("t3_um_strobes",
            32'({img_rden_a, sin_rden, ram_rden_a, ram_wren_a}), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_out("t3_um", 4'd7, 24'd155836, 24'd0, 1'b1);

        // 4: eight loads with a five-cycle output stall
        @(posedge clk);
        #1;
        q_alu.delete();
        q_data.delete();
        out_ready = 1'b0;
        drive(1, 1, 0, 4'd1, 24'd90300, 24'd0);
        @(negedge clk);
        chk("t4_acc0", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'd1, 24'd90301, 24'd0);
        @(negedge clk);
        chk("t4_acc1", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'd1, 24'd90302, 24'd0);
        @(negedge clk);
        chk("t4_drop", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_full_ready", 32'(in_ready), 0);
        chk("t4_full_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("t4_acc2");
        for (int k = 3; k < 8; k++) begin
            drive(1, 1, 0, 4'd1, 24'(90300 + k), 24'd0);
            wait_accept("t4_acc");
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_count", 32'(q_alu.size()), 8);
        for (int k = 0; k < 8 && k < q_alu.size(); k++) begin
            chk("t4_alu", 32'(q_alu[k]), 32'(90300 + k));
            chk("t4_data", 32'(q_data[k]), 32'h860000 + 32'(k));
        end

        // 5: display port
        b_addr = 18'd89999;
        @(negedge clk);
        chk("t5_img_addr_b", 32'(img_addr_b), 89999);
        @(posedge clk);
        #1;
        b_addr = 18'd90100;
        @(negedge clk);
        chk("t5_b_img", 32'(b_data), 32'hA95F8F);
        @(posedge clk);
        #1;
        b_addr = 18'd90301;
        @(negedge clk);
        chk("t5_b_sin", 32'(b_data), 0);
        chk("t5_ram_addr_b", 32'(ram_addr_b), 1);
        @(posedge clk);
        #1;
        b_addr = 18'd0;
        @(negedge clk);
        chk("t5_b_ram", 32'(b_data), 32'hCA0001);

        // 6: reset with entries queued and one in flight
        @(posedge clk);
        #1;
        q_alu.delete();
        q_data.delete();
        out_ready = 1'b0;
        drive(1, 1, 0, 4'd2, 24'd5, 24'd0);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'd2, 24'd6, 24'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 4'd0, 24'd90301, 24'h55AA55);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_wren", 32'(ram_wren_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_hold_wren", 32'(ram_wren_a), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rel_ready", 32'(in_ready), 1);
        chk("t6_rel_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(q_alu.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
